host_frame_transmit_gate: RTL and testbench

Host output-side framer for the TSN NIC: the transmit counterpart of the host input frame selector. Drains complete frames from a show-ahead (FWFT) frame FIFO and drives them to the host MAC interface as a 9-bit byte stream, bit 8 marking the head and tail bytes. Enforces a minimum inter-frame gap, pads runt frames to the Ethernet minimum, and discards whole frames until the hardware initialisation has finished. Maintains transmitted-frame and discarded-frame counters.

---
 rtl/host_frame_transmit_gate_if.sv | 44 ++++
 rtl/host_frame_transmit_gate.sv | 192 +++++++++++++++++++
 tb/tb_host_frame_transmit_gate.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/host_frame_transmit_gate_if.sv
`default_nettype none
// ============================================================================
// Module  : host_frame_transmit_gate_if
// Brief   : FIFO-side and MAC-side signal bundle for host_frame_transmit_gate.
// Revision: 1.0 - initial release
// ============================================================================
interface host_frame_transmit_gate_if;
    logic        i_hardware_initial_finish;
    logic        i_frame_ready;
    logic        i_fifo_empty;
    logic [8:0]  iv_fifo_rdata;
    logic        o_fifo_rd;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic [31:0] ov_tx_pkt_cnt;
    logic [31:0] ov_discard_pkt_cnt;

    // Gate side: consumes the FIFO, produces the MAC byte stream
    modport master (
        input  i_hardware_initial_finish,
        input  i_frame_ready,
        input  i_fifo_empty,
        input  iv_fifo_rdata,
        output o_fifo_rd,
        output ov_data,
        output o_data_wr,
        output ov_tx_pkt_cnt,
        output ov_discard_pkt_cnt
    );

    // Environment side: FIFO model and MAC sink
    modport slave (
        output i_hardware_initial_finish,
        output i_frame_ready,
        output i_fifo_empty,
        output iv_fifo_rdata,
        input  o_fifo_rd,
        input  ov_data,
        input  o_data_wr,
        input  ov_tx_pkt_cnt,
        input  ov_discard_pkt_cnt
    );
endinterface
`default_nettype wire

// File: rtl/host_frame_transmit_gate.sv
`default_nettype none
// ============================================================================
// Module  : host_frame_transmit_gate
// Brief   : Drains frames from an FWFT frame FIFO to the host MAC with IFG
//           enforcement, optional runt padding (macro TX_PADDING_EN) and
//           whole-frame discard until hardware initialisation has finished.
// Revision: 1.0 - initial release
// ============================================================================
module host_frame_transmit_gate #(
    parameter int IFG_CYCLES    = 12,
    parameter int MIN_FRAME_LEN = 60
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst_n,
    host_frame_transmit_gate_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRAN    = 3'd1,
        ST_IFG     = 3'd3,
        ST_DISCARD = 3'd4
`ifdef TX_PADDING_EN
        ,ST_PAD    = 3'd2
`endif
    } state_t;

    localparam logic [10:0] c_IDX_MAX  = 11'd2047;
    localparam logic [7:0]  c_IFG_LOAD = 8'(IFG_CYCLES - 1);

    generate
        if (IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_check_ifg
            $error("IFG_CYCLES out of range 1..255");
        end
        if (MIN_FRAME_LEN < 14 || MIN_FRAME_LEN > 2047) begin : g_check_min
            $error("MIN_FRAME_LEN out of range 14..2047");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_data;
    logic [8:0]  w_data_nxt;
    logic        r_data_wr;
    logic        w_data_wr_nxt;
    logic [10:0] r_idx;
    logic [10:0] w_idx_nxt;
    logic [10:0] w_idx_inc;
    logic [7:0]  r_ifg;
    logic [7:0]  w_ifg_nxt;
    logic [31:0] r_tx_cnt;
    logic [31:0] r_disc_cnt;
    logic        w_fifo_rd;
    logic        w_tx_inc;
    logic        w_disc_inc;
    logic        w_is_tail;

`ifdef TX_PADDING_EN
    localparam logic [11:0] c_MIN_LEN  = 12'(MIN_FRAME_LEN);
    localparam logic [10:0] c_PAD_LAST = 11'(MIN_FRAME_LEN - 1);
    logic w_len_ok;
    assign w_len_ok = ({1'b0, r_idx} + 12'd1) >= c_MIN_LEN;
`endif

    assign w_idx_inc = (r_idx == c_IDX_MAX) ? c_IDX_MAX : r_idx + 11'd1;
    // The head is consumed in IDLE, so inside a frame any marked word at a
    // non-zero index closes it.
    assign w_is_tail = bus.iv_fifo_rdata[8] && (r_idx != 11'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_data     <= 9'd0;
            r_data_wr  <= 1'b0;
            r_idx      <= 11'd0;
            r_ifg      <= 8'd0;
            r_tx_cnt   <= 32'd0;
            r_disc_cnt <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_data_wr <= w_data_wr_nxt;
            r_idx     <= w_idx_nxt;
            r_ifg     <= w_ifg_nxt;
            if (w_tx_inc) begin
                r_tx_cnt <= r_tx_cnt + 32'd1;
            end
            if (w_disc_inc) begin
                r_disc_cnt <= r_disc_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = 9'd0;
        w_data_wr_nxt = 1'b0;
        w_idx_nxt     = r_idx;
        w_ifg_nxt     = r_ifg;
        w_fifo_rd     = 1'b0;
        w_tx_inc      = 1'b0;
        w_disc_inc    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.i_frame_ready && !bus.i_fifo_empty) begin
                    w_fifo_rd = 1'b1;
                    // Transmit/discard is decided once, at the head word
                    if (bus.i_hardware_initial_finish) begin
                        w_data_nxt    = bus.iv_fifo_rdata;
                        w_data_wr_nxt = 1'b1;
                        w_tx_inc      = 1'b1;
                        w_idx_nxt     = 11'd1;
                        w_state_nxt   = ST_TRAN;
                    end else begin
                        w_disc_inc  = 1'b1;
                        w_idx_nxt   = 11'd1;
                        w_state_nxt = ST_DISCARD;
                    end
                end
            end

            ST_TRAN: begin
                if (!bus.i_fifo_empty) begin
                    w_fifo_rd     = 1'b1;
                    w_data_wr_nxt = 1'b1;
                    w_data_nxt    = bus.iv_fifo_rdata;
                    w_idx_nxt     = w_idx_inc;
                    if (w_is_tail) begin
`ifdef TX_PADDING_EN
                        if (w_len_ok) begin
                            w_ifg_nxt   = c_IFG_LOAD;
                            w_state_nxt = ST_IFG;
                        end else begin
                            w_data_nxt  = {1'b0, bus.iv_fifo_rdata[7:0]};
                            w_state_nxt = ST_PAD;
                        end
`else
                        w_ifg_nxt   = c_IFG_LOAD;
                        w_state_nxt = ST_IFG;
`endif
                    end
                end
            end

`ifdef TX_PADDING_EN
            ST_PAD: begin
                w_data_wr_nxt = 1'b1;
                w_idx_nxt     = w_idx_inc;
                if (r_idx == c_PAD_LAST) begin
                    w_data_nxt  = 9'h100;
                    w_ifg_nxt   = c_IFG_LOAD;
                    w_state_nxt = ST_IFG;
                end
            end
`endif

            ST_IFG: begin
                if (r_ifg == 8'd0) begin
                    w_idx_nxt   = 11'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ifg_nxt = r_ifg - 8'd1;
                end
            end

            ST_DISCARD: begin
                if (!bus.i_fifo_empty) begin
                    w_fifo_rd = 1'b1;
                    w_idx_nxt = w_idx_inc;
                    if (w_is_tail) begin
                        w_idx_nxt   = 11'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_idx_nxt   = 11'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_fifo_rd          = w_fifo_rd;
    assign bus.ov_data            = r_data;
    assign bus.o_data_wr          = r_data_wr;
    assign bus.ov_tx_pkt_cnt      = r_tx_cnt;
    assign bus.ov_discard_pkt_cnt = r_disc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_host_frame_transmit_gate.sv
`default_nettype none
// ============================================================================
// Module  : tb_host_frame_transmit_gate
// Brief   : Scoreboard bench: FIFO model + expected-byte queue, with a
//           separate monitor comparing the MAC stream and counters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_host_frame_transmit_gate;

    localparam int TB_IFG = 12;
    localparam int TB_MIN = 60;

    logic clk;
    logic rst_n;
    host_frame_transmit_gate_if bus ();

    host_frame_transmit_gate #(
        .IFG_CYCLES    (TB_IFG),
        .MIN_FRAME_LEN (TB_MIN)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Owned by the stimulus process
    logic [8:0]  fifo_q[$];
    logic [8:0]  exp_q[$];
    int          tails = 0;
    bit          init_fin = 0;
    bit          force_empty = 0;
    bit          pop_in_frame = 0;
    int          head_pop_cyc = 0;
    logic [31:0] exp_tx, exp_disc;
    int          exp_gap, exp_bubble, exp_lat;
    int          chk_seq = 0;

    // Owned by the monitor process
    int total = 0;
    int bad = 0;
    int rd_ptr = 0;
    bit in_frame = 0;
    bit seen_tail = 0;
    int idle_run = 0;
    int last_gap = -1;
    int bubble_run = 0;
    int last_bubble = 0;
    int last_head_cyc = 0;
    int chk_done = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cmp("rst_data_wr", {31'd0, bus.o_data_wr}, 32'd0);
            cmp("rst_data", {23'd0, bus.ov_data}, 32'd0);
            cmp("rst_tx_cnt", bus.ov_tx_pkt_cnt, 32'd0);
            cmp("rst_disc_cnt", bus.ov_discard_pkt_cnt, 32'd0);
            rd_ptr = exp_q.size();
            in_frame = 0; seen_tail = 0; idle_run = 0; bubble_run = 0;
        end else if (bus.o_data_wr) begin
            if (rd_ptr < exp_q.size()) begin
                cmp("stream_byte", {23'd0, bus.ov_data}, {23'd0, exp_q[rd_ptr]});
                rd_ptr++;
            end else begin
                total++; bad++;
                $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", bus.ov_data, cyc);
            end
            if (in_frame && bubble_run > last_bubble) last_bubble = bubble_run;
            bubble_run = 0;
            if (bus.ov_data[8] && !in_frame) begin
                if (seen_tail) last_gap = idle_run;
                last_head_cyc = cyc;
                in_frame = 1;
                last_bubble = 0;
            end else if (bus.ov_data[8]) begin
                in_frame = 0;
                seen_tail = 1;
                idle_run = 0;
            end
        end else begin
            cmp("idle_data_zero", {23'd0, bus.ov_data}, 32'd0);
            if (in_frame) bubble_run++;
            else idle_run++;
        end

        if (chk_done != chk_seq) begin
            cmp("tx_cnt", bus.ov_tx_pkt_cnt, exp_tx);
            cmp("discard_cnt", bus.ov_discard_pkt_cnt, exp_disc);
            cmp("bytes_consumed", rd_ptr, exp_q.size());
            if (exp_gap >= 0) cmp("ifg_gap", last_gap, exp_gap);
            if (exp_bubble >= 0) cmp("bubble_len", last_bubble, exp_bubble);
            if (exp_lat >= 0) cmp("pop_to_head", last_head_cyc - head_pop_cyc, exp_lat);
            chk_done = chk_seq;
        end
    end

    task automatic drive();
        bus.i_hardware_initial_finish = init_fin;
        bus.i_fifo_empty  = (fifo_q.size() == 0) || force_empty;
        bus.iv_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 9'd0;
        bus.i_frame_ready = (tails > 0);
    endtask

    // One clock: sample the pop request away from the edge, apply it after
    task automatic step();
        bit         rd;
        int         rd_cyc;
        logic [8:0] w;
        @(negedge clk);
        rd = bus.o_fifo_rd;
        rd_cyc = cyc;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            if (w[8]) begin
                if (!pop_in_frame) begin
                    pop_in_frame = 1;
                    head_pop_cyc = rd_cyc;
                end else begin
                    pop_in_frame = 0;
                    tails--;
                end
            end
        end
        drive();
    endtask

    task automatic push_frame(input int len, input logic [7:0] seed, input bit sent);
        logic [7:0] b;
        bit         last;
        for (int i = 0; i < len; i++) begin
            b = seed + 8'(i);
            last = (i == len - 1);
            fifo_q.push_back({(i == 0) || last, b});
            if (sent) begin
`ifdef TX_PADDING_EN
                exp_q.push_back({(i == 0) || (last && len >= TB_MIN), b});
`else
                exp_q.push_back({(i == 0) || last, b});
`endif
            end
        end
`ifdef TX_PADDING_EN
        if (sent) begin
            for (int i = len; i < TB_MIN; i++)
                exp_q.push_back((i == TB_MIN - 1) ? 9'h100 : 9'h000);
        end
`endif
        tails++;
        drive();
    endtask

    task automatic request_check(input logic [31:0] tx, input logic [31:0] disc,
                                 input int gap, input int bubble, input int lat);
        exp_tx = tx; exp_disc = disc;
        exp_gap = gap; exp_bubble = bubble; exp_lat = lat;
        chk_seq++;
        for (int i = 0; i < 5 && chk_done != chk_seq; i++) step();
        if (chk_done != chk_seq) begin
            $display("FAIL check_timeout: got no monitor response expected one within 5 cycles");
            $fatal(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Not initialised: three frames are popped silently and counted as discards
        push_frame(20, 8'h00, 0);
        push_frame(14, 8'h40, 0);
        push_frame(30, 8'h80, 0);
        repeat (100) step();
        request_check(32'd0, 32'd3, -1, -1, -1);

        // 64-byte frame, FIFO never empty: contiguous, head one cycle after pop
        init_fin = 1;
        drive();
        push_frame(64, 8'h10, 1);
        repeat (100) step();
        request_check(32'd1, 32'd3, -1, 0, 1);

        // Back-to-back frames: idle run between tail and next head is the IFG
        push_frame(64, 8'h20, 1);
        push_frame(64, 8'h60, 1);
        repeat (180) step();
        request_check(32'd3, 32'd3, TB_IFG, 0, 1);

        // Runt frame: padded to the minimum, or sent as-is when padding is off
        push_frame(42, 8'hA0, 1);
        repeat (100) step();
        request_check(32'd4, 32'd3, -1, 0, 1);

        // Three-cycle FIFO starvation and init drop mid-frame
        push_frame(64, 8'h50, 1);
        repeat (20) step();
        force_empty = 1;
        init_fin = 0;
        drive();
        repeat (3) step();
        force_empty = 0;
        drive();
        repeat (80) step();
        request_check(32'd5, 32'd3, -1, 3, 1);
        init_fin = 1;
        drive();

        // Reset in the middle of a frame, then a fresh frame
        push_frame(64, 8'hC0, 1);
        repeat (10) step();
        rst_n = 1'b0;
        fifo_q.delete();
        tails = 0;
        pop_in_frame = 0;
        drive();
        step();
        rst_n = 1'b1;
        step();
        push_frame(20, 8'h33, 1);
        repeat (100) step();
        request_check(32'd1, 32'd0, -1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
